// File: rtl/axi_bus_arbiter.sv
// Round-robin arbiter sharing one simple-AXI slave port between NUM_MASTERS masters.
// Optional data-phase watchdog enabled by defining AXI_ARB_TIMEOUT_EN (adds the timeout port).
module axi_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_MASTERS*(AXI_ADDR_WIDTH+1)-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]                    m_avalid,
  input  logic [NUM_MASTERS-1:0]                    m_awrite,
  output logic [NUM_MASTERS-1:0]                    m_aready,
  input  logic [NUM_MASTERS-1:0]                    m_wvalid,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]     m_wdata,
  output logic [NUM_MASTERS-1:0]                    m_wready,
  output logic [NUM_MASTERS-1:0]                    m_rvalid,
  input  logic [NUM_MASTERS-1:0]                    m_rready,
  output logic [AXI_DATA_WIDTH-1:0]                 m_rdata,
  output logic [AXI_ADDR_WIDTH:0]                   s_addr,
  output logic                                      s_avalid,
  output logic                                      s_awrite,
  input  logic                                      s_aready,
  output logic                                      s_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]                 s_wdata,
  input  logic                                      s_wready,
  input  logic                                      s_rvalid,
  output logic                                      s_rready,
  input  logic [AXI_DATA_WIDTH-1:0]                 s_rdata,
  output logic [NUM_MASTERS-1:0]                    grant,
`ifdef AXI_ARB_TIMEOUT_EN
  output logic                                      busy,
  output logic                                      timeout
`else
  output logic                                      busy
`endif
);

  localparam int AW = AXI_ADDR_WIDTH + 1;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axi_bus_arbiter: unsupported parameter values");
  end

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

  state_t                   state, state_nxt;
  logic [NUM_MASTERS-1:0]   grant_nxt;
  logic [IW-1:0]            gidx, gidx_nxt;
  logic [IW-1:0]            last_idx, last_nxt;
  logic [IW-1:0]            pick_idx, cand_idx;
  logic                     pick_valid;
  logic                     done;
  int                       cand;

  logic [AW-1:0]             addr_arr  [NUM_MASTERS];
  logic [AXI_DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = m_addr[i*AW +: AW];
    assign wdata_arr[i] = m_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  end

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SATURATE = CW'(TIMEOUT_CYCLES);
  localparam logic [31:0] DEAD_WORD = 32'hDEAD_BEEF;

  logic [CW-1:0]             tcount;
  logic                      tabort;
  logic [AXI_DATA_WIDTH-1:0] dead_data;

  for (genvar i = 0; i < AXI_DATA_WIDTH; i++) begin : g_dead
    assign dead_data[i] = DEAD_WORD[i % 32];
  end

  assign tabort = ((state == WDATA) || (state == RDATA)) && (tcount >= LIMIT);

  // Counter parks one past LIMIT so the abort pulse fires only once while a read abort waits for rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcount <= '0;
    end else if (state == ADDR) begin
      tcount <= '0;
    end else if (((state == WDATA) || (state == RDATA)) && !done && (tcount != SATURATE)) begin
      tcount <= tcount + 1'b1;
    end
  end
`endif

  // Scan upward from the master after last_grant, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand     = (int'(last_idx) + k) % NUM_MASTERS;
      cand_idx = cand[IW-1:0];
      if (!pick_valid && m_avalid[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    gidx_nxt  = gidx;
    last_nxt  = last_idx;
    done      = 1'b0;
    m_aready  = '0;
    m_wready  = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    s_addr    = '0;
    s_avalid  = 1'b0;
    s_awrite  = 1'b0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_rready  = 1'b0;
`ifdef AXI_ARB_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt           = ADDR;
          gidx_nxt            = pick_idx;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
        end
      end
      ADDR: begin
        s_addr         = addr_arr[gidx];
        s_avalid       = m_avalid[gidx];
        s_awrite       = m_awrite[gidx];
        m_aready[gidx] = s_aready;
        if (!m_avalid[gidx]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (s_aready) begin
          state_nxt = m_awrite[gidx] ? WDATA : RDATA;
        end
      end
      WDATA: begin
        s_wvalid       = m_wvalid[gidx];
        s_wdata        = wdata_arr[gidx];
        m_wready[gidx] = s_wready;
        done           = m_wvalid[gidx] && s_wready;
`ifdef AXI_ARB_TIMEOUT_EN
        if (tabort) begin
          s_wvalid       = 1'b0;
          s_wdata        = '0;
          m_wready       = '0;
          m_wready[gidx] = 1'b1;
          timeout        = 1'b1;
          done           = 1'b1;
        end
`endif
      end
      RDATA: begin
        s_rready       = m_rready[gidx];
        m_rvalid[gidx] = s_rvalid;
        m_rdata        = s_rdata;
        done           = s_rvalid && m_rready[gidx];
`ifdef AXI_ARB_TIMEOUT_EN
        if (tabort) begin
          s_rready       = 1'b0;
          m_rvalid       = '0;
          m_rvalid[gidx] = 1'b1;
          m_rdata        = dead_data;
          timeout        = (tcount == LIMIT);
          done           = m_rready[gidx];
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
    if (done) begin
      state_nxt = IDLE;
      grant_nxt = '0;
      last_nxt  = gidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      gidx     <= '0;
      last_idx <= IW'(NUM_MASTERS - 1);
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      gidx     <= gidx_nxt;
      last_idx <= last_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/axi_bus_arbiter.md
Name: axi_bus_arbiter

Overview:
- Shares one slave port of the team's simple AXI bus between NUM_MASTERS requesters.
- The bus is a single address channel (ADDR/AVALID/AREADY/AWRITE), a write-data channel (WVALID/WREADY/WDATA) and a read-data channel (RVALID/RREADY/RDATA).
- Round-robin grant is held from the address handshake until the data phase completes, so one transaction is outstanding at a time.
- Sits between CPU/DMA-style masters and a peripheral slave, e.g. a timer register block.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- AXI_ADDR_WIDTH, 32, address width; the ADDR field is AXI_ADDR_WIDTH+1 bits wide.
- AXI_DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 256, data-phase watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m_addr  in  NUM_MASTERS*(AXI_ADDR_WIDTH+1)  per-master ADDR, master i at slice i.
- m_avalid  in  NUM_MASTERS  per-master AVALID.
- m_awrite  in  NUM_MASTERS  per-master AWRITE (1=write).
- m_aready  out  NUM_MASTERS  per-master AREADY.
- m_wvalid  in  NUM_MASTERS  per-master WVALID.
- m_wdata  in  NUM_MASTERS*AXI_DATA_WIDTH  per-master WDATA.
- m_wready  out  NUM_MASTERS  per-master WREADY.
- m_rvalid  out  NUM_MASTERS  per-master RVALID.
- m_rready  in  NUM_MASTERS  per-master RREADY.
- m_rdata  out  AXI_DATA_WIDTH  RDATA, broadcast to all masters.
- s_addr  out  AXI_ADDR_WIDTH+1  slave ADDR.
- s_avalid  out  1  slave AVALID.
- s_awrite  out  1  slave AWRITE.
- s_aready  in  1  slave AREADY.
- s_wvalid  out  1  slave WVALID.
- s_wdata  out  AXI_DATA_WIDTH  slave WDATA.
- s_wready  in  1  slave WREADY.
- s_rvalid  in  1  slave RVALID.
- s_rready  out  1  slave RREADY.
- s_rdata  in  AXI_DATA_WIDTH  slave RDATA.
- grant  out  NUM_MASTERS  one-hot current grant; 0 in IDLE.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- **Handshakes:** every handshake completes on a cycle where valid&&ready is high.
- **States:** IDLE, ADDR, WDATA, RDATA; held in a registered FSM.
- **Reset:**
  - state=IDLE, grant=0, last_grant=NUM_MASTERS-1 so master 0 wins first.
  - All s_* valid/ready outputs 0; all m_* ready/valid outputs 0; s_addr, s_wdata and m_rdata 0.
  - Reset mid-transaction abandons the transaction; outputs are at reset values on the next edge.
- **IDLE:**
  - If any m_avalid is set, pick the first requester scanning upward from last_grant+1 (mod NUM_MASTERS).
  - Register the one-hot grant and go to ADDR.
  - Arbitration latency is exactly 1 cycle; no slave-side signal is driven in IDLE.
- **ADDR:**
  - Granted master's addr/avalid/awrite are muxed to s_*, and s_aready is routed to its m_aready only.
  - On s_avalid&&s_aready: latch awrite, go to WDATA (write) or RDATA (read).
  - If the granted master drops avalid before the handshake: go to IDLE, grant=0, last_grant unchanged.
- **WDATA:**
  - Route wvalid/wdata of the grantee and return s_wready to it.
  - On the handshake: last_grant=grant, go to IDLE.
- **RDATA:**
  - Route the grantee's rready to s_rready; s_rvalid goes to its m_rvalid only.
  - m_rdata=s_rdata combinationally.
  - On the handshake: last_grant=grant, go to IDLE.
- **Non-granted masters:** always see aready/wready/rvalid=0.
- **Requests while busy:** new requests are ignored until IDLE. Back-to-back throughput is therefore at least 1 idle cycle between transactions, and a minimum transaction is 3 cycles (IDLE, ADDR, data).
- **Simultaneous requests:** round-robin guarantees each requester waits at most NUM_MASTERS-1 transactions.
- **Mux datapath:** purely combinational from grant; no data buffering.

Optional Feature:
- Macro: AXI_ARB_TIMEOUT_EN.
- **Defined:**
  - A counter clears on entry to WDATA or RDATA and increments each data-phase cycle without a handshake.
  - When the count reaches TIMEOUT_CYCLES-1, the arbiter completes the beat itself.
    - WDATA: pulse m_wready to the grantee for 1 cycle.
    - RDATA: hold m_rvalid with m_rdata=32'hDEAD_BEEF (replicated/truncated to AXI_DATA_WIDTH) until m_rready.
  - Extra output timeout (1 bit) pulses for one cycle at abort; then go to IDLE and update last_grant.
  - Slave-side valid/ready are deasserted during the abort cycle.
- **Undefined:** no counter, no timeout port; the data phase waits indefinitely.

Test Plan:
- Reset, then m0 write addr=0x10 data=0xA5A5_0001 -> grant=01 one cycle after avalid; s_addr=0x10, s_wdata matches; m_wready[0] pulses; busy drops after the write handshake.
- m0 and m1 assert avalid in the same cycle, each issuing 2 reads -> grant order 01,10,01,10; m_rvalid is never set on the non-granted master.
- Read from m1 with slave rvalid delayed 5 cycles and rdata=0x1234_5678 -> m_rvalid[1] rises the same cycle as s_rvalid, m_rdata=0x1234_5678, m_rready[1] reaches s_rready.
- m0 asserts avalid, is granted, drops avalid before s_aready -> IDLE next cycle; a following m1 request is served while m0's priority is kept (last_grant unchanged).
- rst asserted during the RDATA phase -> next cycle busy=0, grant=0, s_rready=0; a fresh m0 request is granted first.
- With AXI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, read with no s_rvalid -> after 16 data cycles m_rvalid=1, m_rdata=0xDEAD_BEEF, timeout pulses once.
